// File: rtl/bus_pkg.sv
// Shared constants and types for param_bus_datapath: non-GPR bus source offsets,
// source count helper, index-width helper and the MDR read FSM state type.
package bus_pkg;

   // Non-GPR sources sit directly above the GPRs, in descending priority.
   localparam int SRC_HI_OFS    = 0;
   localparam int SRC_LO_OFS    = 1;
   localparam int SRC_ZHI_OFS   = 2;
   localparam int SRC_ZLO_OFS   = 3;
   localparam int SRC_PC_OFS    = 4;
   localparam int SRC_MDR_OFS   = 5;
   localparam int NUM_EXTRA_SRC = 6;

   typedef enum logic {
      MDR_IDLE = 1'b0,
      MDR_WAIT = 1'b1
   } mdr_state_e;

   function automatic int num_src(input int num_gpr);
      return num_gpr + NUM_EXTRA_SRC;
   endfunction

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/param_bus_datapath_if.sv
// Bus/handshake bundle of param_bus_datapath; master drives controls, slave is the datapath.
interface param_bus_datapath_if #(
   parameter int DATA_W  = 32,
   parameter int NUM_GPR = 16
);
   logic [NUM_GPR-1:0]        gpr_in;
   logic [NUM_GPR-1:0]        gpr_out;
   logic                      hi_in, lo_in, pc_in, ir_in, y_in, mar_in, z_in, mdr_in;
   logic                      hi_out, lo_out, pc_out, zhigh_out, zlow_out, mdr_out;
   logic                      mem_read;
   logic                      mem_ready;
   logic [DATA_W-1:0]         mem_datain;
   logic [2*DATA_W-1:0]       alu_result;
   logic [DATA_W-1:0]         bus_out;
   logic [NUM_GPR*DATA_W-1:0] gpr_q;
   logic [DATA_W-1:0]         hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
   logic [2*DATA_W-1:0]       z_q;
   logic                      mdr_busy;
   logic                      bus_conflict;
   logic                      mdr_timeout;

   modport master (
      output gpr_in, gpr_out,
      output hi_in, lo_in, pc_in, ir_in, y_in, mar_in, z_in, mdr_in,
      output hi_out, lo_out, pc_out, zhigh_out, zlow_out, mdr_out,
      output mem_read, mem_ready, mem_datain, alu_result,
      input  bus_out, gpr_q, hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q, z_q,
      input  mdr_busy, bus_conflict, mdr_timeout
   );

   modport slave (
      input  gpr_in, gpr_out,
      input  hi_in, lo_in, pc_in, ir_in, y_in, mar_in, z_in, mdr_in,
      input  hi_out, lo_out, pc_out, zhigh_out, zlow_out, mdr_out,
      input  mem_read, mem_ready, mem_datain, alu_result,
      output bus_out, gpr_q, hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q, z_q,
      output mdr_busy, bus_conflict, mdr_timeout
   );

endinterface

// File: rtl/prio_encoder.sv
// Lowest-index-wins priority encoder with any-active and more-than-one-active flags.
module prio_encoder
   import bus_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid,
   output logic             o_multi
);

   always_comb begin
      o_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = IDX_W'(i);
      end
   end

   assign o_valid = |i_req;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign o_multi = |(i_req & (i_req - WIDTH'(1)));

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus register datapath: GPRs, HI/LO/PC/IR/Y/MAR, Z and a memory-read MDR FSM.
// Optional `define MDR_TIMEOUT_EN aborts a stalled memory read after MEM_TIMEOUT WAIT cycles.
module param_bus_datapath
   import bus_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NUM_GPR     = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                 Clk,
   input logic                 clr,
   param_bus_datapath_if.slave bus
);

   localparam int NUM_SRC = num_src(NUM_GPR);
   localparam int IDX_W   = idx_w(NUM_SRC);
   localparam int CNT_W   = idx_w(MEM_TIMEOUT + 1);

   logic [DATA_W-1:0]   r_gpr [NUM_GPR];
   logic [DATA_W-1:0]   r_hi, r_lo, r_pc, r_ir, r_y, r_mar, r_mdr;
   logic [2*DATA_W-1:0] r_z;
   mdr_state_e          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
`ifdef MDR_TIMEOUT_EN
   logic                r_tmo;
`endif

   logic [NUM_SRC-1:0]  w_req;
   logic [DATA_W-1:0]   w_src [NUM_SRC];
   logic [IDX_W-1:0]    w_idx;
   logic                w_valid;
   logic                w_multi;
   logic [DATA_W-1:0]   w_bus;

   always_comb begin
      w_req[NUM_GPR-1:0]               = bus.gpr_out;
      w_req[NUM_GPR + SRC_HI_OFS]      = bus.hi_out;
      w_req[NUM_GPR + SRC_LO_OFS]      = bus.lo_out;
      w_req[NUM_GPR + SRC_ZHI_OFS]     = bus.zhigh_out;
      w_req[NUM_GPR + SRC_ZLO_OFS]     = bus.zlow_out;
      w_req[NUM_GPR + SRC_PC_OFS]      = bus.pc_out;
      w_req[NUM_GPR + SRC_MDR_OFS]     = bus.mdr_out;
   end

   always_comb begin
      for (int k = 0; k < NUM_GPR; k++) w_src[k] = r_gpr[k];
      w_src[NUM_GPR + SRC_HI_OFS]  = r_hi;
      w_src[NUM_GPR + SRC_LO_OFS]  = r_lo;
      w_src[NUM_GPR + SRC_ZHI_OFS] = r_z[2*DATA_W-1:DATA_W];
      w_src[NUM_GPR + SRC_ZLO_OFS] = r_z[DATA_W-1:0];
      w_src[NUM_GPR + SRC_PC_OFS]  = r_pc;
      // During a pending read the MDR still drives its previous contents.
      w_src[NUM_GPR + SRC_MDR_OFS] = r_mdr;
   end

   prio_encoder #(
      .WIDTH (NUM_SRC),
      .IDX_W (IDX_W)
   ) u_prio (
      .i_req   (w_req),
      .o_idx   (w_idx),
      .o_valid (w_valid),
      .o_multi (w_multi)
   );

   always_comb begin
      w_bus = '0;
      if (w_valid) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (w_idx == IDX_W'(k)) w_bus = w_src[k];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (clr) begin
         for (int k = 0; k < NUM_GPR; k++) r_gpr[k] <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_pc  <= '0;
         r_ir  <= '0;
         r_y   <= '0;
         r_mar <= '0;
         r_z   <= '0;
      end else begin
         for (int k = 0; k < NUM_GPR; k++) begin
            if (bus.gpr_in[k]) r_gpr[k] <= w_bus;
         end
         if (bus.hi_in)  r_hi  <= w_bus;
         if (bus.lo_in)  r_lo  <= w_bus;
         if (bus.pc_in)  r_pc  <= w_bus;
         if (bus.ir_in)  r_ir  <= w_bus;
         if (bus.y_in)   r_y   <= w_bus;
         if (bus.mar_in) r_mar <= w_bus;
         if (bus.z_in)   r_z   <= bus.alu_result;
      end
   end

   // MDR load / memory-read FSM; mdr_in is ignored while a read is pending.
   always_ff @(posedge Clk) begin
      if (clr) begin
         r_state <= MDR_IDLE;
         r_cnt   <= '0;
         r_mdr   <= '0;
         r_busy  <= 1'b0;
`ifdef MDR_TIMEOUT_EN
         r_tmo   <= 1'b0;
`endif
      end else begin
`ifdef MDR_TIMEOUT_EN
         r_tmo <= 1'b0;
`endif
         case (r_state)
            MDR_IDLE: begin
               if (bus.mdr_in) begin
                  if (!bus.mem_read) begin
                     r_mdr <= w_bus;
                  end else if (bus.mem_ready) begin
                     r_mdr <= bus.mem_datain;
                  end else begin
                     r_state <= MDR_WAIT;
                     r_busy  <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
            end
            MDR_WAIT: begin
               if (bus.mem_ready) begin
                  r_mdr   <= bus.mem_datain;
                  r_state <= MDR_IDLE;
                  r_busy  <= 1'b0;
`ifdef MDR_TIMEOUT_EN
               end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  r_state <= MDR_IDLE;
                  r_busy  <= 1'b0;
                  r_tmo   <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= MDR_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bus_out      = w_bus;
   assign bus.bus_conflict = w_multi;

   for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr_q
      assign bus.gpr_q[g*DATA_W +: DATA_W] = r_gpr[g];
   end

   assign bus.hi_q     = r_hi;
   assign bus.lo_q     = r_lo;
   assign bus.pc_q     = r_pc;
   assign bus.ir_q     = r_ir;
   assign bus.y_q      = r_y;
   assign bus.mar_q    = r_mar;
   assign bus.mdr_q    = r_mdr;
   assign bus.z_q      = r_z;
   assign bus.mdr_busy = r_busy;
`ifdef MDR_TIMEOUT_EN
   assign bus.mdr_timeout = r_tmo;
`else
   assign bus.mdr_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_param_bus_datapath.sv
// Scoreboard bench for param_bus_datapath; follows MDR_TIMEOUT_EN to pick the stall scenario.
module tb_param_bus_datapath;

   localparam int DATA_W      = 32;
   localparam int NUM_GPR     = 16;
   localparam int MEM_TIMEOUT = 15;

   localparam int K_BUS = 0, K_CONF = 1, K_Y = 2, K_MDR = 3, K_BUSY = 4, K_TMO = 5,
                  K_Z = 6, K_PC = 7, K_HI = 8, K_LO = 9, K_GPR5 = 10, K_GPR2 = 11,
                  K_GPRANY = 12, K_MAR = 13, K_IR = 14;

   typedef struct {
      string       tag;
      int          kind;
      logic [63:0] val;
   } sb_item_t;

   logic     Clk = 1'b0;
   logic     clr;
   int       checks = 0;
   int       errors = 0;
   sb_item_t sb[$];

   param_bus_datapath_if #(.DATA_W(DATA_W), .NUM_GPR(NUM_GPR)) bus_if ();

   param_bus_datapath #(
      .DATA_W      (DATA_W),
      .NUM_GPR     (NUM_GPR),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .Clk (Clk),
      .clr (clr),
      .bus (bus_if.slave)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] obs(input int k);
      case (k)
         K_BUS:    return 64'(bus_if.bus_out);
         K_CONF:   return 64'(bus_if.bus_conflict);
         K_Y:      return 64'(bus_if.y_q);
         K_MDR:    return 64'(bus_if.mdr_q);
         K_BUSY:   return 64'(bus_if.mdr_busy);
         K_TMO:    return 64'(bus_if.mdr_timeout);
         K_Z:      return bus_if.z_q;
         K_PC:     return 64'(bus_if.pc_q);
         K_HI:     return 64'(bus_if.hi_q);
         K_LO:     return 64'(bus_if.lo_q);
         K_GPR5:   return 64'(bus_if.gpr_q[5*DATA_W +: DATA_W]);
         K_GPR2:   return 64'(bus_if.gpr_q[2*DATA_W +: DATA_W]);
         K_GPRANY: return 64'(|bus_if.gpr_q);
         K_MAR:    return 64'(bus_if.mar_q);
         K_IR:     return 64'(bus_if.ir_q);
         default:  return 64'hDEAD_DEAD_DEAD_DEAD;
      endcase
   endfunction

   task automatic want(input string tag, input int k, input logic [63:0] v);
      sb.push_back('{tag: tag, kind: k, val: v});
   endtask

   task automatic drain();
      sb_item_t it;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         chk(it.tag, obs(it.kind), it.val);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus_if.gpr_in     = '0;
      bus_if.gpr_out    = '0;
      bus_if.hi_in      = 1'b0;
      bus_if.lo_in      = 1'b0;
      bus_if.pc_in      = 1'b0;
      bus_if.ir_in      = 1'b0;
      bus_if.y_in       = 1'b0;
      bus_if.mar_in     = 1'b0;
      bus_if.z_in       = 1'b0;
      bus_if.mdr_in     = 1'b0;
      bus_if.hi_out     = 1'b0;
      bus_if.lo_out     = 1'b0;
      bus_if.pc_out     = 1'b0;
      bus_if.zhigh_out  = 1'b0;
      bus_if.zlow_out   = 1'b0;
      bus_if.mdr_out    = 1'b0;
      bus_if.mem_read   = 1'b0;
      bus_if.mem_ready  = 1'b0;
      bus_if.mem_datain = '0;
      bus_if.alu_result = '0;
   endtask

   task automatic load_mdr_mem(input logic [DATA_W-1:0] v);
      bus_if.mdr_in     = 1'b1;
      bus_if.mem_read   = 1'b1;
      bus_if.mem_ready  = 1'b1;
      bus_if.mem_datain = v;
      step();
      idle();
   endtask

   task automatic start_read();
      bus_if.mdr_in   = 1'b1;
      bus_if.mem_read = 1'b1;
      step();
      idle();
   endtask

   initial begin
      idle();
      clr = 1'b1;
      step();
      step();
      clr = 1'b0;
      want("rst_bus", K_BUS, 0);
      want("rst_conf", K_CONF, 0);
      want("rst_y", K_Y, 0);
      want("rst_mdr", K_MDR, 0);
      want("rst_z", K_Z, 0);
      want("rst_pc", K_PC, 0);
      want("rst_gpr", K_GPRANY, 0);
      want("rst_busy", K_BUSY, 0);
      want("rst_tmo", K_TMO, 0);
      drain();

      // GPR5 via MDR, fanned out to MAR/IR on the same edge
      load_mdr_mem(32'hDEADBEEF);
      want("mdr_direct", K_MDR, 64'hDEADBEEF);
      want("mdr_direct_busy", K_BUSY, 0);
      drain();
      bus_if.mdr_out = 1'b1;
      bus_if.gpr_in[5] = 1'b1;
      bus_if.mar_in = 1'b1;
      bus_if.ir_in = 1'b1;
      settle();
      want("bus_mdr", K_BUS, 64'hDEADBEEF);
      drain();
      step();
      idle();
      want("gpr5", K_GPR5, 64'hDEADBEEF);
      want("mar_multi", K_MAR, 64'hDEADBEEF);
      want("ir_multi", K_IR, 64'hDEADBEEF);
      drain();
      bus_if.gpr_out[5] = 1'b1;
      bus_if.y_in = 1'b1;
      step();
      idle();
      want("y_from_gpr5", K_Y, 64'hDEADBEEF);
      drain();

      // GPR2=0x11, PC=HI=0x22
      load_mdr_mem(32'h11);
      bus_if.mdr_out = 1'b1;
      bus_if.gpr_in[2] = 1'b1;
      step();
      idle();
      load_mdr_mem(32'h22);
      bus_if.mdr_out = 1'b1;
      bus_if.pc_in = 1'b1;
      bus_if.hi_in = 1'b1;
      step();
      idle();
      want("gpr2", K_GPR2, 64'h11);
      want("pc", K_PC, 64'h22);
      want("hi_multi", K_HI, 64'h22);
      drain();

      bus_if.gpr_out[2] = 1'b1;
      bus_if.pc_out = 1'b1;
      settle();
      want("prio_gpr_pc", K_BUS, 64'h11);
      want("conf_gpr_pc", K_CONF, 1);
      drain();
      idle();
      bus_if.pc_out = 1'b1;
      settle();
      want("pc_alone", K_BUS, 64'h22);
      want("conf_single", K_CONF, 0);
      drain();
      idle();
      bus_if.lo_out = 1'b1;
      bus_if.mdr_out = 1'b1;
      settle();
      want("prio_lo_mdr", K_BUS, 0);
      want("conf_lo_mdr", K_CONF, 1);
      drain();
      idle();

      // MDR from bus
      bus_if.gpr_out[2] = 1'b1;
      bus_if.mdr_in = 1'b1;
      step();
      idle();
      want("mdr_from_bus", K_MDR, 64'h11);
      drain();

      // Memory read that completes after three WAIT cycles
      start_read();
      want("wait_busy1", K_BUSY, 1);
      drain();
      bus_if.mdr_out = 1'b1;
      bus_if.y_in = 1'b1;
      bus_if.mdr_in = 1'b1;
      settle();
      want("wait_bus_old", K_BUS, 64'h11);
      drain();
      step();
      idle();
      want("wait_busy2", K_BUSY, 1);
      want("wait_y_live", K_Y, 64'h11);
      want("wait_mdr_held", K_MDR, 64'h11);
      drain();
      step();
      want("wait_busy3", K_BUSY, 1);
      drain();
      bus_if.mem_ready = 1'b1;
      bus_if.mem_datain = 32'hCAFE0001;
      step();
      idle();
      want("read_done_busy", K_BUSY, 0);
      want("read_done_mdr", K_MDR, 64'hCAFE0001);
      drain();

      // Z register halves
      bus_if.z_in = 1'b1;
      bus_if.alu_result = 64'h00000001_80000000;
      step();
      idle();
      want("z", K_Z, 64'h00000001_80000000);
      drain();
      bus_if.zhigh_out = 1'b1;
      settle();
      want("zhigh", K_BUS, 64'h1);
      drain();
      idle();
      bus_if.zlow_out = 1'b1;
      settle();
      want("zlow", K_BUS, 64'h80000000);
      drain();
      idle();

`ifdef MDR_TIMEOUT_EN
      start_read();
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         want("to_busy", K_BUSY, 1);
         want("to_nopulse", K_TMO, 0);
         drain();
         step();
      end
      want("to_pulse", K_TMO, 1);
      want("to_idle", K_BUSY, 0);
      want("to_mdr_kept", K_MDR, 64'hCAFE0001);
      drain();
      step();
      want("to_pulse_end", K_TMO, 0);
      drain();

      start_read();
      for (int i = 1; i < MEM_TIMEOUT; i++) step();
      bus_if.mem_ready = 1'b1;
      bus_if.mem_datain = 32'h5A5A5A5A;
      step();
      idle();
      want("race_mdr", K_MDR, 64'h5A5A5A5A);
      want("race_nopulse", K_TMO, 0);
      want("race_idle", K_BUSY, 0);
      drain();
`else
      start_read();
      for (int i = 0; i < 20; i++) begin
         want("stall_busy", K_BUSY, 1);
         want("stall_tmo", K_TMO, 0);
         drain();
         step();
      end
`endif

      if (!bus_if.mdr_busy) start_read();
      step();
      step();
      clr = 1'b1;
      bus_if.mdr_out = 1'b1;
      bus_if.y_in = 1'b1;
      bus_if.mem_ready = 1'b1;
      bus_if.mem_datain = 32'h77;
      step();
      clr = 1'b0;
      idle();
      want("clr_wait_busy", K_BUSY, 0);
      want("clr_wait_mdr", K_MDR, 0);
      want("clr_wait_y", K_Y, 0);
      want("clr_wait_tmo", K_TMO, 0);
      drain();
      for (int i = 0; i < MEM_TIMEOUT + 2; i++) begin
         step();
         want("clr_no_pulse", K_TMO, 0);
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/param_bus_datapath.md
PARAM_BUS_DATAPATH -- requirements
Module: param_bus_datapath

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bus and register width.
REQ-002 SHALL have parameter NUM_GPR, default 16, meaning general-purpose register count (2..32).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, meaning maximum mem_ready wait in cycles.
REQ-004 SHALL have ports:
  Clk  in  1  clock, all state on rising edge
  clr  in  1  reset, synchronous, active-high
  gpr_in  in  NUM_GPR  per-GPR load enables
  gpr_out  in  NUM_GPR  per-GPR bus drive requests
  hi_in, lo_in, pc_in, ir_in, y_in, mar_in, z_in, mdr_in  in  1 each  register loads
  hi_out, lo_out, pc_out, zhigh_out, zlow_out, mdr_out  in  1 each  bus drive requests
  mem_read  in  1  MDR load source select: 1 = memory, 0 = bus
  mem_ready  in  1  memory data valid
  mem_datain  in  DATA_W  memory read data
  alu_result  in  2*DATA_W  ALU output to Z
  bus_out  out  DATA_W  current bus value
  gpr_q  out  NUM_GPR*DATA_W  flattened GPRs, GPR0 in LSBs
  hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q  out  DATA_W each  register contents
  z_q  out  2*DATA_W  Z register
  mdr_busy  out  1  memory read in progress
  bus_conflict  out  1  more than one drive request this cycle
  mdr_timeout  out  1  one-cycle pulse on read abort

Function
REQ-005 Bus sources in priority order: GPR0..GPRn-1, HI, LO, Zhigh, Zlow, PC, MDR.
REQ-006 bus_out SHALL be combinational: value of highest-priority active source; 0 when none active.
REQ-007 bus_conflict SHALL be combinational, 1 when two or more drive requests are active.
REQ-008 Each register with its load enable high SHALL capture bus_out at the rising edge; one-cycle latency.
REQ-009 Multiple loads in one cycle SHALL all capture the same bus_out.
REQ-010 z_in SHALL capture alu_result into z_q; Zhigh = z_q[2W-1:W], Zlow = z_q[W-1:0].
REQ-011 MDR FSM states IDLE, WAIT. In IDLE, mdr_in with mem_read=0 SHALL load bus_out into mdr_q next edge.
REQ-012 IDLE with mdr_in=1, mem_read=1: mem_ready=1 that edge loads mem_datain directly; else go to WAIT, counter=0.
REQ-013 WAIT: mdr_busy=1; mem_ready=1 loads mem_datain and returns to IDLE; else counter increments.
REQ-014 mdr_in SHALL be ignored while in WAIT; all other registers SHALL keep operating.
REQ-015 MDR as bus source during WAIT SHALL drive the old mdr_q.
REQ-016 mdr_busy SHALL equal (state==WAIT), registered.

Reset
REQ-017 clr=1 at an edge SHALL zero every register, z_q, counter, and mdr_timeout; FSM to IDLE.
REQ-018 clr SHALL override all loads, including mid-WAIT; a pending read is dropped without pulse.

Configuration
REQ-019 With MDR_TIMEOUT_EN defined: in WAIT, counter reaching MEM_TIMEOUT without mem_ready SHALL return to IDLE, keep mdr_q, pulse mdr_timeout one cycle.
REQ-020 Without MDR_TIMEOUT_EN: WAIT SHALL persist until mem_ready or clr; mdr_timeout tied 0.
REQ-021 mem_ready on the same edge as timeout expiry SHALL win (data loaded, no pulse).

Structure
REQ-022 Package bus_pkg SHALL hold source-index constants, NUM_SRC = NUM_GPR+6, and the MDR state typedef.
REQ-023 Sub-module prio_encoder (parametrised width, one-hot-to-index plus valid and multi-hot flags) SHALL implement bus selection.

Verification
REQ-024 clr, gpr_out[3]=0 with bus idle -> bus_out=0, all q=0, bus_conflict=0.
REQ-025 Load GPR5=0xDEADBEEF via mdr path, then gpr_out[5]=1, y_in=1 -> y_q=0xDEADBEEF next cycle.
REQ-026 gpr_out[2]=1 and pc_out=1 together (GPR2=0x11, PC=0x22) -> bus_out=0x11, bus_conflict=1.
REQ-027 mdr_in, mem_read=1, mem_ready after 3 cycles with 0xCAFE0001 -> mdr_busy 3 cycles, mdr_q=0xCAFE0001.
REQ-028 MDR_TIMEOUT_EN, MEM_TIMEOUT=15, mem_ready never -> mdr_timeout pulse after 15 WAIT cycles, mdr_q unchanged; clr during WAIT -> IDLE, no pulse.
REQ-029 z_in with alu_result=0x00000001_80000000, then zhigh_out -> bus 0x1; zlow_out -> bus 0x80000000.
